// File: rtl/alu_2_pkg.sv
// Shared MIPS-I encodings for the execute/next-PC core: opcodes, R-type funct
// codes, REGIMM rt codes and immediate-extension helpers.
package alu_2_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MTHI   = 6'h11;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_MTLO   = 6'h13;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_MULTU  = 6'h19;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [5:0] FN_DIVU   = 6'h1B;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_SLT    = 6'h2A;
  localparam logic [5:0] FN_SLTU   = 6'h2B;

  // REGIMM branch selectors (instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_2_if.sv
// Decoded-instruction / operand / result bundle between the CPU top level and
// the execute core. master = top level (drives operands), slave = alu_2.
interface alu_2_if;
  logic        clk_enable;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] branch_address;
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [5:0]  functcode;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [31:0] alu_result;
  logic        sig_branch;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output clk_enable, pc_in, opcode, rt_field, functcode, shamt, immediate,
           rs_content, rt_content,
    input  pc_out, pc_plus4, branch_address, alu_result, sig_branch, hi, lo
  );

  modport slave (
    input  clk_enable, pc_in, opcode, rt_field, functcode, shamt, immediate,
           rs_content, rt_content,
    output pc_out, pc_plus4, branch_address, alu_result, sig_branch, hi, lo
  );
endinterface

// File: rtl/alu_2_pc_reg.sv
// Program counter register: loads the reset vector on synchronous reset and
// otherwise takes the muxed next PC whenever the core is enabled.
module alu_2_pc_reg #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_out
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = clk_enable ? pc_in : pc_q;
  end

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/alu_2.sv
// Execute/next-PC core of the single-cycle MIPS-I CPU: PC and its adders,
// integer ALU, branch condition and the HI/LO multiply/divide registers.
module alu_2
  import alu_2_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  alu_2_if.slave bus
);

  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign rs    = bus.rs_content;
  assign rt    = bus.rt_content;
  assign imm_s = sext16(bus.immediate);
  assign imm_z = zext16(bus.immediate);

  alu_2_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (bus.clk_enable),
    .pc_in      (bus.pc_in),
    .pc_out     (pc)
  );

  // Next-PC adders
  always_comb begin
    pc_plus4           = pc + 32'd4;
    bus.pc_out         = pc;
    bus.pc_plus4       = pc_plus4;
    bus.branch_address = pc_plus4 + {imm_s[29:0], 2'b00};
  end

  logic [31:0] hi_d, hi_q;
  logic [31:0] lo_d, lo_q;

  // ALU result
  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.alu_result = '0;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.functcode)
          FN_SLL:  bus.alu_result = rt << bus.shamt;
          FN_SRL:  bus.alu_result = rt >> bus.shamt;
          FN_SRA:  bus.alu_result = $signed(rt) >>> bus.shamt;
          FN_SLLV: bus.alu_result = rt << rs[4:0];
          FN_SRLV: bus.alu_result = rt >> rs[4:0];
          FN_SRAV: bus.alu_result = $signed(rt) >>> rs[4:0];
          FN_ADDU: bus.alu_result = rs + rt;
          FN_SUBU: bus.alu_result = rs - rt;
          FN_AND:  bus.alu_result = rs & rt;
          FN_OR:   bus.alu_result = rs | rt;
          FN_XOR:  bus.alu_result = rs ^ rt;
          FN_SLT:  bus.alu_result = {31'b0, $signed(rs) < $signed(rt)};
          FN_SLTU: bus.alu_result = {31'b0, rs < rt};
          FN_MFHI: bus.alu_result = hi_q;
          FN_MFLO: bus.alu_result = lo_q;
          default: bus.alu_result = '0;
        endcase
      end
      OP_ADDIU: bus.alu_result = rs + imm_s;
      OP_SLTI:  bus.alu_result = {31'b0, $signed(rs) < $signed(imm_s)};
      OP_SLTIU: bus.alu_result = {31'b0, rs < imm_s};
      OP_ANDI:  bus.alu_result = rs & imm_z;
      OP_ORI:   bus.alu_result = rs | imm_z;
      OP_XORI:  bus.alu_result = rs ^ imm_z;
      OP_LUI:   bus.alu_result = {bus.immediate, 16'h0000};
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SW:
                bus.alu_result = rs + imm_s;
      default:  bus.alu_result = '0;
    endcase
  end

  // Branch condition
  always_comb begin
    bus.sig_branch = 1'b0;
    case (bus.opcode)
      OP_BEQ:  bus.sig_branch = (rs == rt);
      OP_BNE:  bus.sig_branch = (rs != rt);
      OP_BLEZ: bus.sig_branch = rs[31] || (rs == 32'd0);
      OP_BGTZ: bus.sig_branch = !rs[31] && (rs != 32'd0);
      OP_REGIMM: begin
        case (bus.rt_field)
          RT_BLTZ, RT_BLTZAL: bus.sig_branch = rs[31];
          RT_BGEZ, RT_BGEZAL: bus.sig_branch = !rs[31];
          default:            bus.sig_branch = 1'b0;
        endcase
      end
      default: bus.sig_branch = 1'b0;
    endcase
  end

  // HI/LO next state; divide-by-zero falls through and holds both registers
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'h0, rs} * {32'h0, rt};
    if (bus.clk_enable && (bus.opcode == OP_RTYPE)) begin
      case (bus.functcode)
        FN_MULT:  {hi_d, lo_d} = prod_s;
        FN_MULTU: {hi_d, lo_d} = prod_u;
        FN_DIV: begin
          if (rt != 32'd0) begin
            lo_d = $signed(rs) / $signed(rt);
            hi_d = $signed(rs) % $signed(rt);
          end
        end
        FN_DIVU: begin
          if (rt != 32'd0) begin
            lo_d = rs / rt;
            hi_d = rs % rt;
          end
        end
        FN_MTHI: hi_d = rs;
        FN_MTLO: lo_d = rs;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_alu_2.sv
// Self-checking bench for alu_2: expectations are queued when stimulus is
// applied and popped/compared once the DUT outputs are valid.
module tb_alu_2;
  import alu_2_pkg::*;

  typedef enum logic [2:0] {
    S_PC, S_PC4, S_BRA, S_ALU, S_BR, S_HI, S_LO
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  alu_2_if bus();

  alu_2 #(
    .RESET_VECTOR (32'hBFC0_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_PC:    return bus.pc_out;
      S_PC4:   return bus.pc_plus4;
      S_BRA:   return bus.branch_address;
      S_ALU:   return bus.alu_result;
      S_BR:    return {31'b0, bus.sig_branch};
      S_HI:    return bus.hi;
      default: return bus.lo;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs_v, input logic [31:0] rt_v,
                       input logic [15:0] imm, input logic [4:0] sh,
                       input logic [4:0] rtf);
    bus.opcode     = op;
    bus.functcode  = fn;
    bus.rs_content = rs_v;
    bus.rt_content = rt_v;
    bus.immediate  = imm;
    bus.shamt      = sh;
    bus.rt_field   = rtf;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Reset must win over clk_enable and a pending MTHI
    reset = 1'b1;
    bus.clk_enable = 1'b1;
    bus.pc_in = 32'h1234_5678;
    drive(OP_RTYPE, FN_MTHI, 32'h55, 32'h0, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("rst_pc",  S_PC,  32'hBFC0_0000);
    expect_val("rst_pc4", S_PC4, 32'hBFC0_0004);
    expect_val("rst_hi",  S_HI,  32'h0);
    expect_val("rst_lo",  S_LO,  32'h0);
    drain();

    // clk_enable=0 holds PC and HI
    reset = 1'b0;
    bus.clk_enable = 1'b0;
    bus.pc_in = 32'h0000_0010;
    tick();
    expect_val("hold_pc", S_PC, 32'hBFC0_0000);
    expect_val("hold_hi", S_HI, 32'h0);
    drain();

    bus.clk_enable = 1'b1;
    drive(OP_RTYPE, FN_SLL, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("pc_load", S_PC, 32'h0000_0010);
    drain();

    bus.pc_in = 32'h0000_0100;
    tick();
    bus.clk_enable = 1'b0;
    expect_val("pc_100", S_PC, 32'h0000_0100);

    // Branch target and conditions
    drive(OP_BEQ, 6'h0, 32'd5, 32'd5, 16'hFFFF, 5'd0, 5'd0);
    expect_val("br_addr", S_BRA, 32'h0000_0100);
    expect_val("beq_t",   S_BR,  32'd1);
    expect_val("beq_alu", S_ALU, 32'd0);
    drain();
    drive(OP_BEQ, 6'h0, 32'd5, 32'd6, 16'h0010, 5'd0, 5'd0);
    expect_val("br_fwd", S_BRA, 32'h0000_0144);
    expect_val("beq_nt", S_BR,  32'd0);
    drain();
    drive(OP_BNE,    6'h0, 32'd5, 32'd6, 16'h0, 5'd0, 5'd0);  expect_val("bne_t",  S_BR, 32'd1); drain();
    drive(OP_REGIMM, 6'h0, 32'd0, 32'd0, 16'h0, 5'd0, RT_BLTZ); expect_val("bltz0", S_BR, 32'd0); drain();
    drive(OP_REGIMM, 6'h0, 32'hFFFF_FFFF, 32'd0, 16'h0, 5'd0, RT_BLTZ); expect_val("bltzn", S_BR, 32'd1); drain();
    drive(OP_REGIMM, 6'h0, 32'd0, 32'd0, 16'h0, 5'd0, RT_BGEZAL); expect_val("bgezal0", S_BR, 32'd1); drain();
    drive(OP_BLEZ,   6'h0, 32'd0, 32'd0, 16'h0, 5'd0, 5'd0);  expect_val("blez0",  S_BR, 32'd1); drain();
    drive(OP_BGTZ,   6'h0, 32'd0, 32'd0, 16'h0, 5'd0, 5'd0);  expect_val("bgtz0",  S_BR, 32'd0); drain();
    drive(OP_BGTZ,   6'h0, 32'd1, 32'd0, 16'h0, 5'd0, 5'd0);  expect_val("bgtz1",  S_BR, 32'd1); drain();

    // ALU results
    drive(OP_RTYPE, FN_ADDU, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd0, 5'd0); expect_val("addu", S_ALU, 32'h0); drain();
    drive(OP_RTYPE, FN_SUBU, 32'd3, 32'd5, 16'h0, 5'd0, 5'd0); expect_val("subu", S_ALU, 32'hFFFF_FFFE); drain();
    drive(OP_RTYPE, FN_SLT,  32'hFFFF_FFFF, 32'd1, 16'h0, 5'd0, 5'd0); expect_val("slt", S_ALU, 32'd1); drain();
    drive(OP_RTYPE, FN_SLTU, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd0, 5'd0); expect_val("sltu", S_ALU, 32'd0); drain();
    drive(OP_RTYPE, FN_SRA,  32'h0, 32'h8000_0000, 16'h0, 5'd4, 5'd0); expect_val("sra", S_ALU, 32'hF800_0000); drain();
    drive(OP_RTYPE, FN_SRLV, 32'h24, 32'h8000_0000, 16'h0, 5'd0, 5'd0); expect_val("srlv", S_ALU, 32'h0800_0000); drain();
    drive(OP_RTYPE, FN_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 16'h0, 5'd0, 5'd0); expect_val("xor", S_ALU, 32'hF00F_F00F); drain();
    drive(OP_RTYPE, 6'h3F,   32'h1, 32'h1, 16'h0, 5'd0, 5'd0); expect_val("bad_fn", S_ALU, 32'h0); drain();
    drive(OP_LUI,   6'h0, 32'h0, 32'h0, 16'h1234, 5'd0, 5'd0); expect_val("lui", S_ALU, 32'h1234_0000); drain();
    drive(OP_ORI,   6'h0, 32'hF000_0000, 32'h0, 16'h8001, 5'd0, 5'd0); expect_val("ori", S_ALU, 32'hF000_8001); drain();
    drive(OP_SLTI,  6'h0, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, 5'd0, 5'd0); expect_val("slti", S_ALU, 32'd1); drain();
    drive(OP_SLTIU, 6'h0, 32'd5, 32'h0, 16'hFFFF, 5'd0, 5'd0); expect_val("sltiu", S_ALU, 32'd1); drain();
    drive(OP_LW,    6'h0, 32'h0000_1000, 32'h0, 16'hFFFC, 5'd0, 5'd0);
    expect_val("lw_addr", S_ALU, 32'h0000_0FFC);
    expect_val("lw_br",   S_BR,  32'd0);
    drain();
    drive(6'h3F, 6'h0, 32'h1, 32'h1, 16'h1, 5'd0, 5'd0); expect_val("bad_op", S_ALU, 32'h0); drain();

    // HI/LO: disabled MULT must not update
    drive(OP_RTYPE, FN_MULT, 32'hFFFF_FFFF, 32'd2, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("mult_off_hi", S_HI, 32'h0);
    expect_val("mult_off_lo", S_LO, 32'h0);
    drain();
    bus.clk_enable = 1'b1;
    tick();
    expect_val("mult_hi", S_HI, 32'hFFFF_FFFF);
    expect_val("mult_lo", S_LO, 32'hFFFF_FFFE);
    expect_val("pc_keep", S_PC, 32'h0000_0100);
    drain();
    drive(OP_RTYPE, FN_MULTU, 32'hFFFF_FFFF, 32'd2, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("multu_hi", S_HI, 32'h0000_0001);
    expect_val("multu_lo", S_LO, 32'hFFFF_FFFE);
    drain();
    drive(OP_RTYPE, FN_DIV, 32'hFFFF_FFF9, 32'd2, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("div_lo", S_LO, 32'hFFFF_FFFD);
    expect_val("div_hi", S_HI, 32'hFFFF_FFFF);
    drain();
    drive(OP_RTYPE, FN_DIVU, 32'd7, 32'd0, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("divu0_lo", S_LO, 32'hFFFF_FFFD);
    expect_val("divu0_hi", S_HI, 32'hFFFF_FFFF);
    drain();
    drive(OP_RTYPE, FN_DIVU, 32'hFFFF_FFF9, 32'd2, 16'h0, 5'd0, 5'd0);
    tick();
    expect_val("divu_lo", S_LO, 32'h7FFF_FFFC);
    expect_val("divu_hi", S_HI, 32'h0000_0001);
    drain();
    drive(OP_RTYPE, FN_MTLO, 32'h0000_00AB, 32'h0, 16'h0, 5'd0, 5'd0);
    tick();
    bus.clk_enable = 1'b0;
    expect_val("mtlo", S_LO, 32'h0000_00AB);
    expect_val("mtlo_hi", S_HI, 32'h0000_0001);
    drain();
    drive(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0); expect_val("mflo", S_ALU, 32'h0000_00AB); drain();
    drive(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0); expect_val("mfhi", S_ALU, 32'h0000_0001); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
